// File: rtl/uart_tx.sv
// UART transmitter: start bit, WIDTH data bits LSB first, optional even parity, one stop bit.
// Define UART_TX_PARITY_EN to insert the even-parity bit after the MSB.
module uart_tx #(
   parameter int WIDTH   = 8,
   parameter int DIVISOR = 86
) (
   input  logic             clk,
   input  logic             i_reset_n,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_data_valid,
   output logic             o_ready,
   output logic             o_tx,
   output logic             o_done
);

   localparam int CW = $clog2(DIVISOR);
   localparam int IW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DIVISOR - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t           state_reg, state_next;
   logic [CW-1:0]    cnt_reg, cnt_next;
   logic [IW-1:0]    idx_reg, idx_next;
   logic [WIDTH-1:0] shift_reg, shift_next;
   logic             tx_reg, tx_next;
   logic             ready_reg, ready_next;
   logic             done_reg, done_next;
   logic             bit_end;
`ifdef UART_TX_PARITY_EN
   logic             parity_reg, parity_next;
`endif

   assign bit_end = (cnt_reg == CNT_LAST);

   // Outputs are registered alongside the state so o_tx never glitches.
   always_ff @(posedge clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_reg  <= IDLE;
         cnt_reg    <= '0;
         idx_reg    <= '0;
         shift_reg  <= '0;
         tx_reg     <= 1'b1;
         ready_reg  <= 1'b1;
         done_reg   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_reg <= 1'b0;
`endif
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         idx_reg    <= idx_next;
         shift_reg  <= shift_next;
         tx_reg     <= tx_next;
         ready_reg  <= ready_next;
         done_reg   <= done_next;
`ifdef UART_TX_PARITY_EN
         parity_reg <= parity_next;
`endif
      end
   end

   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      idx_next    = idx_reg;
      shift_next  = shift_reg;
`ifdef UART_TX_PARITY_EN
      parity_next = parity_reg;
`endif
      case (state_reg)
         IDLE: begin
            cnt_next = '0;
            idx_next = '0;
            if (i_data_valid && ready_reg) begin
               state_next  = START;
               shift_next  = i_data;
`ifdef UART_TX_PARITY_EN
               parity_next = ^i_data;
`endif
            end
         end
         START: begin
            if (bit_end) begin
               state_next = DATA;
               cnt_next   = '0;
               idx_next   = '0;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         DATA: begin
            if (bit_end) begin
               cnt_next   = '0;
               shift_next = shift_reg >> 1;
               if (idx_reg == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                  state_next = PARITY;
`else
                  state_next = STOP;
`endif
               end else begin
                  idx_next = idx_reg + IW'(1);
               end
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_end) begin
               state_next = STOP;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
`endif
         STOP: begin
            if (bit_end) begin
               state_next = IDLE;
               cnt_next   = '0;
               idx_next   = '0;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
            idx_next   = '0;
         end
      endcase
   end

   // Line level follows the state being entered; the next data bit is always shift_next[0].
   always_comb begin
      tx_next    = 1'b1;
      ready_next = (state_next == IDLE);
      done_next  = (state_reg == STOP) && (state_next == IDLE);
      case (state_next)
         START:   tx_next = 1'b0;
         DATA:    tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  tx_next = parity_next;
`endif
         default: tx_next = 1'b1;
      endcase
   end

   assign o_tx    = tx_reg;
   assign o_ready = ready_reg;
   assign o_done  = done_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: the driver queues each accepted word, a line monitor
// captures every frame cycle by cycle and checks it against the queued word on o_done.
module tb_uart_tx;
   localparam int W = 8;
   localparam int D = 87;
`ifdef UART_TX_PARITY_EN
   localparam int NB = W + 3;
`else
   localparam int NB = W + 2;
`endif
   localparam int FL = NB * D;

   logic         clk = 1'b0;
   logic         i_reset_n = 1'b0;
   logic [W-1:0] i_data = '0;
   logic         i_data_valid = 1'b0;
   logic         o_ready, o_tx, o_done;

   int total = 0;
   int bad = 0;

   logic [W-1:0] exp_q[$];
   int           ncyc = 0;
   int           done_t = -1000;
   bit           gap_chk = 1'b0;
   bit           in_frame = 1'b0;
   int           cyc = 0;
   int           rdy_err = 0;
   int           shape_err = 0;
   logic         cap [0:1023];
   logic         prev_tx = 1'b1;
   logic [W-1:0] mw;

   uart_tx #(.WIDTH(W), .DIVISOR(D)) dut (
      .clk          (clk),
      .i_reset_n    (i_reset_n),
      .i_data       (i_data),
      .i_data_valid (i_data_valid),
      .o_ready      (o_ready),
      .o_tx         (o_tx),
      .o_done       (o_done)
   );

   always #5 clk = ~clk;

   function automatic logic exp_bit(input logic [W-1:0] w, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= W) return w[idx-1];
      if (idx == NB - 1) return 1'b1;
      return ^w;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: capture the line every cycle of a frame, compare against the scoreboard on o_done.
   always @(negedge clk) begin
      ncyc++;
      if (!i_reset_n) begin
         if (in_frame) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            in_frame = 1'b0;
         end
      end else if (in_frame) begin
         cyc++;
         if (o_done) begin
            total++;
            if (cyc != FL) begin
               bad++;
               $display("FAIL frame_len: got %0d cycles expected %0d", cyc, FL);
            end
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL frame_word: frame sent with no word queued");
            end else begin
               mw = exp_q.pop_front();
               shape_err = 0;
               for (int c = 0; c < FL; c++)
                  if (cap[c] !== exp_bit(mw, c / D)) shape_err++;
               if (shape_err != 0) begin
                  bad++;
                  $display("FAIL frame_word: word %02h had %0d wrong line cycles expected 0", mw, shape_err);
               end
            end
            total++;
            if (rdy_err != 0) begin
               bad++;
               $display("FAIL busy_ready: o_ready high %0d cycles in frame expected 0", rdy_err);
            end
            $display("frame done: word=%02h len=%0d queue_left=%0d", mw, cyc, exp_q.size());
            in_frame = 1'b0;
            done_t = ncyc;
         end else if (cyc >= FL + 4) begin
            total++;
            bad++;
            $display("FAIL frame_timeout: no o_done after %0d cycles expected %0d", cyc, FL);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            in_frame = 1'b0;
         end else if (cyc < FL) begin
            cap[cyc] = o_tx;
            if (o_ready) rdy_err++;
         end
      end else begin
         if (o_done) begin
            total++;
            bad++;
            $display("FAIL stray_done: o_done=1 outside a frame expected 0");
         end
         if (o_tx === 1'b0 && prev_tx === 1'b1) begin
            in_frame = 1'b1;
            cyc = 0;
            cap[0] = o_tx;
            rdy_err = o_ready ? 1 : 0;
            if (gap_chk) begin
               chk("idle_gap", ncyc - done_t, 1);
               gap_chk = 1'b0;
            end
         end
      end
      prev_tx = o_tx;
   end

   // Must be entered at a negedge; returns at the negedge after the accept edge.
   task automatic send(input logic [W-1:0] w);
      int n = 0;
      i_data = w;
      i_data_valid = 1'b1;
      while (!o_ready && n < 3 * FL) begin
         @(negedge clk);
         n++;
      end
      chk("send_ready", {31'b0, o_ready}, 1);
      exp_q.push_back(w);
      @(negedge clk);
      chk("accept", {30'b0, o_ready, o_tx}, 0);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((exp_q.size() != 0 || !o_ready || in_frame) && n < 4 * FL) begin
         @(negedge clk);
         n++;
      end
      chk("wait_idle", exp_q.size(), 0);
   endtask

   initial begin
      int err;
      repeat (3) @(negedge clk);
      chk("reset_state", {29'b0, o_tx, o_ready, o_done}, 3'b110);
      i_reset_n = 1'b1;

      err = 0;
      repeat (100) begin
         @(negedge clk);
         if (o_tx !== 1'b1 || o_ready !== 1'b1 || o_done !== 1'b0) err++;
      end
      chk("idle_hold", err, 0);

      // Single frame 0xA5
      send(8'hA5);
      i_data_valid = 1'b0;
      wait_idle();

      // Held valid: 0x00 then 0xFF back to back
      @(negedge clk);
      send(8'h00);
      i_data = 8'hFF;
      @(negedge clk);
      gap_chk = 1'b1;
      send(8'hFF);
      i_data_valid = 1'b0;
      wait_idle();
      chk("gap_checked", {31'b0, gap_chk}, 0);

      // Valid pulse and data change while busy must be ignored
      @(negedge clk);
      send(8'h3C);
      i_data_valid = 1'b0;
      repeat (200) @(negedge clk);
      i_data = 8'hC3;
      i_data_valid = 1'b1;
      @(negedge clk);
      i_data_valid = 1'b0;
      i_data = 8'h5A;
      wait_idle();

      // Reset in the middle of a frame
      @(negedge clk);
      send(8'h55);
      i_data_valid = 1'b0;
      repeat (299) @(negedge clk);
      #2 i_reset_n = 1'b0;
      #1 chk("reset_abort", {29'b0, o_tx, o_ready, o_done}, 3'b110);
      repeat (2) @(negedge clk);
      i_reset_n = 1'b1;
      chk("abort_queue", exp_q.size(), 0);
      err = 0;
      repeat (200) begin
         @(negedge clk);
         if (o_tx !== 1'b1 || o_ready !== 1'b1) err++;
      end
      chk("post_reset_idle", err, 0);

      // Accept on the first edge after reset release
      i_reset_n = 1'b0;
      i_data = 8'h81;
      i_data_valid = 1'b1;
      @(negedge clk);
      exp_q.push_back(8'h81);
      i_reset_n = 1'b1;
      @(negedge clk);
      chk("first_edge_accept", {30'b0, o_ready, o_tx}, 0);
      i_data_valid = 1'b0;
      wait_idle();

      // Parity-sensitive words (parity bit 1 and 0 when enabled)
      @(negedge clk);
      send(8'h07);
      i_data_valid = 1'b0;
      wait_idle();
      @(negedge clk);
      send(8'h03);
      i_data_valid = 1'b0;
      wait_idle();

      // Random back-to-back words
      @(negedge clk);
      for (int i = 0; i < 30; i++) send(W'($urandom));
      i_data_valid = 1'b0;
      wait_idle();

      repeat (5) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

endmodule
